// File: rtl/seq_sll_shifter_pkg.sv
`default_nettype none
// ============================================================
// seq_sll_shifter_pkg : shared ALU function codes and shifter FSM encoding
// Revision: 1.0
// ============================================================
package seq_sll_shifter_pkg;

   localparam logic [5:0] c_fn_sll   = 6'b000000;
   localparam logic [5:0] c_fn_srl   = 6'b000010;
   localparam logic [5:0] c_fn_add   = 6'b100000;
   localparam logic [5:0] c_fn_sub   = 6'b100010;
   localparam logic [5:0] c_fn_and   = 6'b100100;
   localparam logic [5:0] c_fn_or    = 6'b100101;
   localparam logic [5:0] c_fn_slt   = 6'b101010;
   localparam logic [5:0] c_fn_multu = 6'b011001;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_sll_shifter_sll_step.sv
`default_nettype none
// ============================================================
// sll_step : combinational left shift of value by k, zero-filled
// Revision: 1.0
// ============================================================
module sll_step #(
   parameter int WIDTH = 32,
   parameter int KW    = 1
) (
   input  logic [WIDTH-1:0] value,
   input  logic [KW-1:0]    k,
   output logic [WIDTH-1:0] shifted
);

   assign shifted = value << k;

endmodule
`default_nettype wire

// File: rtl/seq_sll_shifter.sv
`default_nettype none
// ============================================================
// seq_sll_shifter : multi-cycle logical left shifter, up to STEP bits/clock
// Revision: 1.0
// ============================================================
module seq_sll_shifter
   import seq_sll_shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       signal,
   input  logic [WIDTH-1:0] dataIn,
   input  logic [31:0]      shamt,
   output logic [WIDTH-1:0] dataOut,
   output logic             busy,
   output logic             done
);

   // Counter wide enough to hold both the shift amount and STEP itself
   localparam int c_kw = $clog2(STEP + 1);
   localparam int c_rw = (SHW > c_kw) ? SHW : c_kw;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] w_work_next;
   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] r_dataout;
   logic [c_rw-1:0]  r_rem;
   logic [c_rw-1:0]  w_rem_next;
   logic [c_rw-1:0]  w_k;
   logic [c_rw-1:0]  w_rem_dec;
   logic             w_accept;
   logic             r_done;
   logic             w_unused_shamt;

   assign w_unused_shamt = ^shamt[31:SHW];

   assign w_k       = (r_rem < c_rw'(STEP)) ? r_rem : c_rw'(STEP);
   assign w_rem_dec = r_rem - w_k;
   assign w_accept  = start && (signal == c_fn_sll);

   sll_step #(
      .WIDTH (WIDTH),
      .KW    (c_rw)
   ) u_sll_step (
      .value   (r_work),
      .k       (w_k),
      .shifted (w_shifted)
   );

   always_comb begin
      w_state_next = r_state;
      w_work_next  = r_work;
      w_rem_next   = r_rem;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_work_next  = dataIn;
               w_rem_next   = c_rw'(shamt[SHW-1:0]);
               w_state_next = (shamt[SHW-1:0] == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_work_next = w_shifted;
            w_rem_next  = w_rem_dec;
            if (w_rem_dec == '0) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // dataOut is loaded on the edge that enters DONE so it is valid with done
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_work    <= '0;
         r_rem     <= '0;
         r_dataout <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_work  <= w_work_next;
         r_rem   <= w_rem_next;
         r_done  <= (w_state_next == S_DONE);
         if (w_state_next == S_DONE) begin
            r_dataout <= w_work_next;
         end
      end
   end

   assign dataOut = r_dataout;
   assign done    = r_done;
   assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seq_sll_shifter.sv
`default_nettype none
// ============================================================
// tb_seq_sll_shifter : randomized bench for STEP=1 and STEP=4 shifters
// Revision: 1.0
// ============================================================
module tb_seq_sll_shifter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  start_v;
   logic [1:0]  busy_v;
   logic [1:0]  done_v;
   logic [5:0]  sig_v  [2];
   logic [31:0] din_v  [2];
   logic [31:0] sh_v   [2];
   logic [31:0] dout_v [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_sll_shifter #(.WIDTH(32), .SHW(5), .STEP(1)) u_s1 (
      .clk(clk), .reset(reset), .start(start_v[0]), .signal(sig_v[0]),
      .dataIn(din_v[0]), .shamt(sh_v[0]), .dataOut(dout_v[0]),
      .busy(busy_v[0]), .done(done_v[0])
   );

   seq_sll_shifter #(.WIDTH(32), .SHW(5), .STEP(4)) u_s4 (
      .clk(clk), .reset(reset), .start(start_v[1]), .signal(sig_v[1]),
      .dataIn(din_v[1]), .shamt(sh_v[1]), .dataOut(dout_v[1]),
      .busy(busy_v[1]), .done(done_v[1])
   );

   function automatic int step_of(input int w);
      return (w == 0) ? 1 : 4;
   endfunction

   // Shift as multiplication by 2^n, truncated to 32 bits
   function automatic logic [31:0] model_res(input logic [31:0] d, input logic [31:0] sh);
      longint unsigned prod;
      int n;
      n = int'(sh % 32);
      prod = longint'(d) * (longint'(1) << n);
      return prod[31:0];
   endfunction

   function automatic int model_lat(input logic [31:0] sh, input int step);
      int n;
      n = int'(sh % 32);
      return (n + step - 1) / step + 1;
   endfunction

   // Issue one SLL request from IDLE and wait for done; lat counts the accept edge as 1
   task automatic do_op(input int w, input logic [31:0] d, input logic [31:0] sh,
                        output int lat, output logic [31:0] res, output logic busy_acc,
                        output logic done_after, output logic busy_after);
      sig_v[w] = 6'b000000; din_v[w] = d; sh_v[w] = sh; start_v[w] = 1'b1;
      @(posedge clk); #1;
      start_v[w] = 1'b0;
      busy_acc = busy_v[w];
      lat = 1;
      while (done_v[w] !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (done_v[w] !== 1'b1) lat = -1;
      res = dout_v[w];
      @(posedge clk); #1;
      done_after = done_v[w];
      busy_after = busy_v[w];
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         for (int w = 0; w < 2; w++) begin
            checks++;
            if (dout_v[w] !== 32'h0 || busy_v[w] !== 1'b0 || done_v[w] !== 1'b0) begin
               errors++;
               $display("FAIL reset_idle[%0d] cyc %0d: got dout=%h busy=%b done=%b want 0/0/0",
                        w, i, dout_v[w], busy_v[w], done_v[w]);
            end
         end
      end
   endtask

   task automatic test_directed();
      logic [31:0] d_tab  [5] = '{32'h0000_0001, 32'hF000_000F, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0001};
      logic [31:0] s_tab  [5] = '{32'd31, 32'hFFFF_FFE5, 32'd0, 32'd0, 32'd31};
      int          w_tab  [5] = '{0, 1, 0, 1, 1};
      logic [31:0] r_tab  [5] = '{32'h8000_0000, 32'h0000_01E0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000};
      int          l_tab  [5] = '{32, 3, 1, 1, 9};
      int lat;
      logic [31:0] res;
      logic ba, da, bb;
      for (int i = 0; i < 5; i++) begin
         do_op(w_tab[i], d_tab[i], s_tab[i], lat, res, ba, da, bb);
         checks++;
         if (lat != l_tab[i] || res !== r_tab[i]) begin
            errors++;
            $display("FAIL directed[%0d]: got lat=%0d dout=%h want lat=%0d dout=%h",
                     i, lat, res, l_tab[i], r_tab[i]);
         end
         checks++;
         if (ba !== 1'b1 || da !== 1'b0 || bb !== 1'b0) begin
            errors++;
            $display("FAIL directed_hs[%0d]: got busy_acc=%b done_after=%b busy_after=%b want 1/0/0",
                     i, ba, da, bb);
         end
      end
   endtask

   task automatic test_reject();
      logic [31:0] prev [2];
      for (int w = 0; w < 2; w++) begin
         prev[w] = dout_v[w];
         sig_v[w] = 6'b000010; din_v[w] = $urandom; sh_v[w] = 32'd3; start_v[w] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         for (int w = 0; w < 2; w++) begin
            checks++;
            if (busy_v[w] !== 1'b0 || done_v[w] !== 1'b0 || dout_v[w] !== prev[w]) begin
               errors++;
               $display("FAIL reject_srl[%0d]: got busy=%b done=%b dout=%h want 0/0/%h",
                        w, busy_v[w], done_v[w], dout_v[w], prev[w]);
            end
         end
      end
      start_v = 2'b00;
      sig_v[0] = 6'b000000; sig_v[1] = 6'b000000;
   endtask

   task automatic test_random();
      int w, lat;
      logic [31:0] d, sh, res;
      logic ba, da, bb;
      for (int i = 0; i < 30; i++) begin
         w  = int'($urandom_range(0, 1));
         d  = $urandom;
         sh = $urandom;
         do_op(w, d, sh, lat, res, ba, da, bb);
         checks++;
         if (lat != model_lat(sh, step_of(w)) || res !== model_res(d, sh) ||
             ba !== 1'b1 || da !== 1'b0 || bb !== 1'b0) begin
            errors++;
            $display("FAIL random[%0d] step%0d d=%h sh=%h: got lat=%0d dout=%h hs=%b%b%b want lat=%0d dout=%h hs=100",
                     i, step_of(w), d, sh, lat, res, ba, da, bb,
                     model_lat(sh, step_of(w)), model_res(d, sh));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] prev;
      int c;
      prev = dout_v[0];
      sig_v[0] = 6'b000000; din_v[0] = 32'h1234_5678; sh_v[0] = 32'd7; start_v[0] = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy_v[0] !== 1'b1 || dout_v[0] !== prev) begin
         errors++;
         $display("FAIL accept_hold: got busy=%b dout=%h want 1/%h", busy_v[0], dout_v[0], prev);
      end
      // New operands with start held high while busy must be ignored
      din_v[0] = 32'hFFFF_FFFF; sh_v[0] = 32'd2;
      c = 1;
      while (done_v[0] !== 1'b1 && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      checks++;
      if (c != model_lat(32'd7, 1) || dout_v[0] !== model_res(32'h1234_5678, 32'd7)) begin
         errors++;
         $display("FAIL busy_ignore: got lat=%0d dout=%h want lat=%0d dout=%h",
                  c, dout_v[0], model_lat(32'd7, 1), model_res(32'h1234_5678, 32'd7));
      end
      @(posedge clk); #1;
      checks++;
      if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: got busy=%b done=%b want 0/0", busy_v[0], done_v[0]);
      end
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      checks++;
      if (busy_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: got busy=%b want 1", busy_v[0]);
      end
      c = 1;
      while (done_v[0] !== 1'b1 && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      checks++;
      if (c != model_lat(32'd2, 1) || dout_v[0] !== model_res(32'hFFFF_FFFF, 32'd2)) begin
         errors++;
         $display("FAIL b2b_result: got lat=%0d dout=%h want lat=%0d dout=%h",
                  c, dout_v[0], model_lat(32'd2, 1), model_res(32'hFFFF_FFFF, 32'd2));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic saw_done;
      sig_v[0] = 6'b000000; din_v[0] = 32'h0000_0001; sh_v[0] = 32'd31; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      repeat (8) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int w = 0; w < 2; w++) begin
         checks++;
         if (busy_v[w] !== 1'b0 || done_v[w] !== 1'b0 || dout_v[w] !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid[%0d]: got busy=%b done=%b dout=%h want 0/0/0",
                     w, busy_v[w], done_v[w], dout_v[w]);
         end
      end
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_done: got activity=%b want 0", saw_done);
      end
   endtask

   initial begin
      start_v = 2'b00;
      for (int w = 0; w < 2; w++) begin
         sig_v[w] = 6'b000000; din_v[w] = 32'h0; sh_v[w] = 32'h0;
      end
      test_reset();
      test_directed();
      test_reject();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
